// File: rtl/prog_loader.sv
// Program loader: parses header/length/payload[/checksum] frames from a byte stream,
// writes the CPU memories and releases cpu_rst after a good load. Define LOADER_CHECKSUM_EN for the checksum byte.
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH:0] MAX_LEN = (DATA_WIDTH+1)'(1 << ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
`endif

    state_t                state_reg, state_next;
    logic                  sel_reg, sel_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_reg, sum_next;
`endif
    logic                  s_ready_reg, s_ready_next;
    logic                  mem_we_reg, mem_we_next;
    logic                  mem_sel_reg, mem_sel_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_din_reg, mem_din_next;
    logic                  cpu_rst_reg, cpu_rst_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic                  fire;

    assign fire = s_valid && s_ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= 1'b0;
            addr_reg     <= '0;
            cnt_reg      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= '0;
`endif
            s_ready_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_sel_reg  <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
            cpu_rst_reg  <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= sum_next;
`endif
            s_ready_reg  <= s_ready_next;
            mem_we_reg   <= mem_we_next;
            mem_sel_reg  <= mem_sel_next;
            mem_addr_reg <= mem_addr_next;
            mem_din_reg  <= mem_din_next;
            cpu_rst_reg  <= cpu_rst_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
`ifdef LOADER_CHECKSUM_EN
        sum_next      = sum_reg;
`endif
        // Writes are a single registered cycle, so the loader never needs to stall.
        s_ready_next  = 1'b1;
        mem_we_next   = 1'b0;
        mem_sel_next  = mem_sel_reg;
        mem_addr_next = mem_addr_reg;
        mem_din_next  = mem_din_reg;
        cpu_rst_next  = cpu_rst_reg;
        done_next     = done_reg;
        err_next      = err_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (fire) begin
                    sel_next     = s_data[DATA_WIDTH-1];
                    addr_next    = s_data[ADDR_WIDTH-1:0];
                    done_next    = 1'b0;
                    err_next     = 1'b0;
                    cpu_rst_next = 1'b1;
                    state_next   = LEN;
                end
            end
            LEN: begin
                if (fire) begin
                    if (s_data == '0 || {1'b0, s_data} > MAX_LEN) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        cnt_next   = s_data[CW-1:0];
`ifdef LOADER_CHECKSUM_EN
                        sum_next   = '0;
`endif
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    mem_we_next   = 1'b1;
                    mem_sel_next  = sel_reg;
                    mem_addr_next = addr_reg;
                    mem_din_next  = s_data;
                    addr_next     = addr_reg + 1'b1;
                    cnt_next      = cnt_reg - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + s_data;
                    if (cnt_reg == CW'(1)) state_next = CSUM;
`else
                    if (cnt_reg == CW'(1)) begin
                        done_next    = 1'b1;
                        cpu_rst_next = 1'b0;
                        state_next   = DONE;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (fire) begin
                    if (s_data == sum_reg) begin
                        done_next    = 1'b1;
                        cpu_rst_next = 1'b0;
                        state_next   = DONE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign s_ready  = s_ready_reg;
    assign mem_we   = mem_we_reg;
    assign mem_sel  = mem_sel_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_din  = mem_din_reg;
    assign cpu_rst  = cpu_rst_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames against a frame-level model with
// an expected-write queue; follows LOADER_CHECKSUM_EN like the design.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, mem_we, mem_sel, cpu_rst, done, err;
    logic [4:0] mem_addr;
    logic [7:0] mem_din;

    int n_checks = 0;
    int n_fail = 0;
    logic [13:0] wq[$];
    logic rst_q = 1'b1;

    always #5 clk = ~clk;

    prog_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // Every write must match the oldest outstanding expected write; s_ready stays high once out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (!rst_q) check("s_ready_high", {31'b0, s_ready}, 32'd1);
            if (mem_we) begin
                if (wq.size() == 0) check("unexpected_we", {31'b0, mem_we}, 32'd0);
                else check("write", {18'b0, mem_sel, mem_addr, mem_din}, {18'b0, wq.pop_front()});
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_sel", {31'b0, mem_sel}, 32'd0);
        check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
        check("rst_mem_din", {24'b0, mem_din}, 32'd0);
        check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] hdr, input logic [7:0] len, input logic [7:0] pl[$],
                             input logic [7:0] csum, input int gap);
        int  sum = 0;
        bit  legal = (len >= 8'd1 && len <= 8'd32);
        bit  good;
        send_byte(hdr, gap);
        check("hdr_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check("hdr_done", {31'b0, done}, 32'd0);
        check("hdr_err", {31'b0, err}, 32'd0);
        send_byte(len, gap);
        if (!legal) begin
            check("badlen_err", {31'b0, err}, 32'd1);
            check("badlen_done", {31'b0, done}, 32'd0);
            check("badlen_cpu_rst", {31'b0, cpu_rst}, 32'd1);
            @(negedge clk);
            check("badlen_no_we", {31'b0, mem_we}, 32'd0);
            $display("frame hdr=%02h len=%0d illegal-length", hdr, len);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            wq.push_back({hdr[7], 5'((int'(hdr[4:0]) + i) % 32), pl[i]});
            sum += int'(pl[i]);
        end
        for (int i = 0; i < int'(len); i++) send_byte(pl[i], gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, gap);
        good = (csum == 8'(sum));
`else
        good = 1'b1;
`endif
        check("end_done", {31'b0, done}, {31'b0, good});
        check("end_err", {31'b0, err}, {31'b0, !good});
        check("end_cpu_rst", {31'b0, cpu_rst}, {31'b0, !good});
        @(negedge clk);
        check("writes_drained", wq.size(), 32'd0);
        $display("frame hdr=%02h len=%0d gap=%0d csum=%02h sum=%02h good=%0d", hdr, len, gap, csum, 8'(sum), good);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr, len, csum;
        int s;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        pl = '{8'hA1, 8'h42, 8'h07};
        run_frame(8'h00, 8'h03, pl, 8'hEA, 0);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(8'h9E, 8'h04, pl, 8'hAA, 0);
        pl = '{8'h10};
        run_frame(8'h05, 8'h01, pl, 8'h11, 0);
        pl = {};
        run_frame(8'h00, 8'h00, pl, 8'h00, 0);
        run_frame(8'h00, 8'h21, pl, 8'h00, 0);

        // Reset in the middle of a frame.
        send_byte(8'h03, 0);
        send_byte(8'h02, 0);
        wq.push_back({1'b0, 5'd3, 8'h5A});
        send_byte(8'h5A, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        wq.delete();
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-frame applied");

        pl = '{8'h55, 8'h66};
        run_frame(8'h00, 8'h02, pl, 8'hBB, 0);
        pl = '{8'h01, 8'h02, 8'h03};
        run_frame(8'h84, 8'h03, pl, 8'h06, 3);

        for (int k = 0; k < 40; k++) begin
            hdr = 8'($urandom);
            if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255));
            else len = 8'($urandom_range(1, 32));
            pl = {};
            s = 0;
            for (int i = 0; i < int'(len) && len <= 8'd32; i++) begin
                pl.push_back(8'($urandom));
                s += int'(pl[i]);
            end
            csum = 8'(s);
            if ($urandom_range(0, 3) == 0) csum = csum ^ 8'($urandom_range(1, 255));
            run_frame(hdr, len, pl, csum, $urandom_range(0, 2));
        end

        check("final_wq_empty", wq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
